// File: rtl/streebog_g_ctrl.sv
// Streebog g_N(h,m) sequencer: alternates one shared combinational LPS unit between
// the key schedule and the message state, then folds in h and m for the final result.
module streebog_g_ctrl #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned ROUNDS     = 12
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] h_i,
  input  logic [DATA_WIDTH-1:0] m_i,
  input  logic [DATA_WIDTH-1:0] n_i,
  output logic [DATA_WIDTH-1:0] lps_in,
  input  logic [DATA_WIDTH-1:0] lps_out,
  output logic [3:0]            c_idx,
  input  logic [DATA_WIDTH-1:0] c_val,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam int unsigned RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [RW-1:0] RND_LAST = RW'(ROUNDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    KLOAD,
    SROUND,
    KROUND,
    FINAL,
    DONE
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] h;
  logic [DATA_WIDTH-1:0] m;
  logic [DATA_WIDTH-1:0] nreg;
  logic [DATA_WIDTH-1:0] key;
  logic [DATA_WIDTH-1:0] st;
  logic [RW-1:0]         rnd;

  assign c_idx = 4'(rnd);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    lps_in    = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = KLOAD;
      end
      KLOAD: begin
        lps_in    = h ^ nreg;
        state_nxt = SROUND;
      end
      SROUND: begin
        lps_in    = st ^ key;
        state_nxt = KROUND;
      end
      KROUND: begin
        lps_in    = key ^ c_val;
        state_nxt = (rnd == RND_LAST) ? FINAL : SROUND;
      end
      FINAL: state_nxt = DONE;
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= IDLE;
      h         <= '0;
      m         <= '0;
      nreg      <= '0;
      key       <= '0;
      st        <= '0;
      rnd       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            h    <= h_i;
            m    <= m_i;
            nreg <= n_i;
          end
        end
        KLOAD: begin
          key <= lps_out;
          st  <= m;
          rnd <= '0;
        end
        SROUND: st <= lps_out;
        KROUND: begin
          key <= lps_out;
          // saturate on the last round so rnd never leaves 0..ROUNDS-1
          if (rnd != RND_LAST) rnd <= rnd + RW'(1);
        end
        FINAL: begin
          out_data  <= st ^ key ^ h ^ m;
          out_valid <= 1'b1;
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_streebog_g_ctrl.sv
// Directed bench for streebog_g_ctrl; provides a stand-in combinational LPS unit and
// constant ROM, and checks the per-cycle LPS operand trace and g_N results against a model.
module tb_streebog_g_ctrl;

  localparam int unsigned DW = 512;
  localparam int unsigned NR = 12;

  logic          clk = 1'b0;
  logic          rstn_i;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] h_i;
  logic [DW-1:0] m_i;
  logic [DW-1:0] n_i;
  logic [DW-1:0] lps_in;
  logic [DW-1:0] lps_out;
  logic [3:0]    c_idx;
  logic [DW-1:0] c_val;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  streebog_g_ctrl #(
    .DATA_WIDTH(DW),
    .ROUNDS    (NR)
  ) dut (
    .clk_i    (clk),
    .rstn_i   (rstn_i),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .h_i      (h_i),
    .m_i      (m_i),
    .n_i      (n_i),
    .lps_in   (lps_in),
    .lps_out  (lps_out),
    .c_idx    (c_idx),
    .c_val    (c_val),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  // Stand-in LPS: nonlinear (AND term) and position-mixing, nonzero at zero input.
  function automatic logic [DW-1:0] lps_f(input logic [DW-1:0] x);
    logic [DW-1:0] r;
    r = {x[510:0], x[511]} ^ {x[12:0], x[511:13]};
    r = r ^ (x & {x[447:0], x[511:448]});
    return ~r;
  endfunction

  function automatic logic [DW-1:0] cval_f(input logic [3:0] idx);
    logic [31:0] w;
    if (idx > 4'd11) return '0;
    w = 32'h9E3779B9 * (32'(idx) + 32'd1);
    return {16{w}};
  endfunction

  function automatic logic [DW-1:0] rand512();
    logic [DW-1:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  always_comb lps_out = lps_f(lps_in);
  always_comb c_val   = cval_f(c_idx);

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present operands and wait (bounded) for the accept edge; returns at the first
  // negedge after it, with the DUT in KLOAD.
  task automatic send(input logic [DW-1:0] h, input logic [DW-1:0] m, input logic [DW-1:0] n);
    int unsigned t;
    t = 0;
    h_i = h; m_i = m; n_i = n; in_valid = 1'b1;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("accept", DW'(in_ready), DW'(1));
    @(negedge clk);
  endtask

  // Walk observation points 0..25 (KLOAD..FINAL) checking lps_in/c_idx, then the result.
  task automatic trace(input logic [DW-1:0] h, input logic [DW-1:0] m, input logic [DW-1:0] n,
                       input int busy_at, input int abort_at, output logic [DW-1:0] res);
    logic [DW-1:0] k;
    logic [DW-1:0] s;
    logic [DW-1:0] lps_exp[26];
    logic [3:0]    cid_exp[26];
    for (int j = 0; j < 26; j++) cid_exp[j] = 4'd0;
    lps_exp[0] = h ^ n;
    k = lps_f(h ^ n);
    s = m;
    for (int r = 0; r < 12; r++) begin
      lps_exp[1 + 2*r] = s ^ k;
      s = lps_f(s ^ k);
      lps_exp[2 + 2*r] = k ^ cval_f(4'(r));
      cid_exp[2 + 2*r] = 4'(r);
      k = lps_f(k ^ cval_f(4'(r)));
    end
    lps_exp[25] = '0;
    res = s ^ k ^ h ^ m;

    for (int j = 0; j < 26; j++) begin
      check($sformatf("lps_in[%0d]", j), lps_in, lps_exp[j]);
      if (j >= 2 && j <= 24 && (j % 2) == 0)
        check($sformatf("c_idx[%0d]", j), DW'(c_idx), DW'(cid_exp[j]));
      check($sformatf("out_valid_busy[%0d]", j), DW'(out_valid), DW'(0));
      if (j == 0) check("in_ready_busy", DW'(in_ready), DW'(0));
      if (j == abort_at) return;
      if (busy_at >= 0 && j == busy_at) begin
        check("in_ready_at_pulse", DW'(in_ready), DW'(0));
        in_valid = 1'b1; h_i = ~h; m_i = ~m; n_i = ~n;
      end
      if (busy_at >= 0 && j == busy_at + 1) in_valid = 1'b0;
      @(negedge clk);
    end
    check("out_valid", DW'(out_valid), DW'(1));
    check("out_data", out_data, res);
    check("in_ready_done", DW'(in_ready), DW'(0));
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    check("out_valid_after_hs", DW'(out_valid), DW'(0));
    check("in_ready_after_hs", DW'(in_ready), DW'(1));
    out_ready = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] m1;
    logic [DW-1:0] kat;
    logic [DW-1:0] res;
    logic [DW-1:0] ha, ma, na, hb, mb, nb, ra, rb;

    for (int i = 0; i < 63; i++) m1[8*i +: 8] = 8'h30 + 8'(i % 10);
    m1[511:504] = 8'h01;

    rstn_i = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    h_i = '0; m_i = '0; n_i = '0;
    @(negedge clk);
    check("rst_in_ready", DW'(in_ready), DW'(1));
    check("rst_out_valid", DW'(out_valid), DW'(0));
    check("rst_out_data", out_data, '0);
    check("rst_lps_in", lps_in, '0);
    check("rst_c_idx", DW'(c_idx), DW'(0));
    rstn_i = 1'b1;
    @(negedge clk);

    // KAT with backpressure in DONE
    send('0, m1, '0);
    in_valid = 1'b0;
    trace('0, m1, '0, -1, -1, kat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", DW'(out_valid), DW'(1));
      check("hold_data", out_data, kat);
    end
    release_out();

    // operands pulsed mid-operation must be ignored
    @(negedge clk);
    send('0, m1, '0);
    in_valid = 1'b0;
    trace('0, m1, '0, 5, -1, res);
    check("busy_vs_kat", res, kat);
    release_out();

    // asynchronous reset during SROUND rnd=5
    @(negedge clk);
    send(rand512(), rand512(), rand512());
    in_valid = 1'b0;
    trace(h_i, m_i, n_i, -1, 11, res);
    rstn_i = 1'b0;
    #1;
    check("midrst_out_valid", DW'(out_valid), DW'(0));
    check("midrst_in_ready", DW'(in_ready), DW'(1));
    check("midrst_lps_in", lps_in, '0);
    check("midrst_c_idx", DW'(c_idx), DW'(0));
    @(negedge clk);
    rstn_i = 1'b1;
    @(negedge clk);
    check("postrst_in_ready", DW'(in_ready), DW'(1));
    check("postrst_out_valid", DW'(out_valid), DW'(0));
    send('0, m1, '0);
    in_valid = 1'b0;
    trace('0, m1, '0, -1, -1, res);
    check("postrst_kat", res, kat);
    release_out();

    // back-to-back with in_valid and out_ready held high
    @(negedge clk);
    ha = rand512(); ma = rand512(); na = rand512();
    hb = rand512(); mb = rand512(); nb = rand512();
    out_ready = 1'b1;
    send(ha, ma, na);
    h_i = hb; m_i = mb; n_i = nb;
    trace(ha, ma, na, -1, -1, ra);
    @(negedge clk);
    check("b2b_gap_out_valid", DW'(out_valid), DW'(0));
    check("b2b_gap_in_ready", DW'(in_ready), DW'(1));
    @(negedge clk);
    in_valid = 1'b0;
    trace(hb, mb, nb, -1, -1, rb);
    @(negedge clk);
    check("b2b_final_out_valid", DW'(out_valid), DW'(0));
    out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
